// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU memory port (master) and the
// memory responder (slave).
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_size;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        resp_valid;
  logic [31:0] readdata;
  logic        err;

  modport master (
    output req_valid, req_we, req_size, adr, writedata,
    input  req_ready, resp_valid, readdata, err
  );

  modport slave (
    input  req_valid, req_we, req_size, adr, writedata,
    output req_ready, resp_valid, readdata, err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory responder with programmable wait states: one request at a time,
// big-endian byte-lane writes, registered read word and one-cycle response strobe.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);
  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [AW+1:0] r_adr;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic          r_size;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_commit;
  logic [AW+1:0] w_adr;
  logic [31:0]   w_wdata;
  logic          w_we;
  logic          w_size;
  logic [31:0]   w_old;
  logic [31:0]   w_merged;
  logic          w_misaligned;
  logic [4:0]    w_shift;
  logic          w_unused_adr;

  assign w_unused_adr = ^bus.adr[31:AW+2];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = (LAT == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready  = (r_state == S_IDLE);
    bus.resp_valid = (r_state == S_RESP);
  end

  assign bus.readdata = r_rdata;
  assign bus.err      = r_err;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);

  // With zero wait states the commit happens on the accept edge, so the live inputs are used.
  assign w_adr   = (r_state == S_IDLE) ? bus.adr[AW+1:0] : r_adr;
  assign w_wdata = (r_state == S_IDLE) ? bus.writedata   : r_wdata;
  assign w_we    = (r_state == S_IDLE) ? bus.req_we      : r_we;
  assign w_size  = (r_state == S_IDLE) ? bus.req_size    : r_size;

  assign w_old        = r_mem[w_adr[AW+1:2]];
  assign w_misaligned = !w_size && (w_adr[1:0] != 2'd0);
  assign w_shift      = {~w_adr[1:0], 3'b000};
  assign w_merged     = w_size ? ((w_old & ~(32'hFF << w_shift)) | ({24'd0, w_wdata[7:0]} << w_shift))
                               : w_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_size  <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= LAT;
        r_adr   <= bus.adr[AW+1:0];
        r_wdata <= bus.writedata;
        r_we    <= bus.req_we;
        r_size  <= bus.req_size;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err   <= w_misaligned;
        r_rdata <= w_misaligned ? 32'd0 : (w_we ? w_merged : w_old);
      end
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && w_commit && w_we && !w_misaligned)
      r_mem[w_adr[AW+1:2]] <= w_merged;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench: a LATENCY=2 and a LATENCY=0 responder checked
// against a byte-array reference model, plus directed boundary and reset cases.
module tb_mem_responder;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  bit [31:0] mdl [2][DEPTH];

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction
  function automatic logic get_rv(input int sel);
    return (sel == 0) ? bus_a.resp_valid : bus_b.resp_valid;
  endfunction
  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 0) ? bus_a.readdata : bus_b.readdata;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus_a.err : bus_b.err;
  endfunction

  task automatic drive(input int sel, input logic v, input logic we, input logic sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_size = sz;
      bus_a.adr = a; bus_a.writedata = wd;
    end else begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_size = sz;
      bus_b.adr = a; bus_b.writedata = wd;
    end
  endtask

  // Reference model: memory as words split into big-endian byte lists.
  task automatic model_op(input int sel, input bit we, input bit sz, input bit [31:0] a,
                          input bit [31:0] wd, output bit [31:0] rd, output bit e);
    int idx = int'(a % (4 * DEPTH)) / 4;
    int lane = int'(a % 4);
    bit [7:0] b [4];
    if (!sz && lane != 0) begin
      rd = 0;
      e  = 1;
      return;
    end
    e = 0;
    for (int i = 0; i < 4; i++) b[i] = mdl[sel][idx][31 - 8*i -: 8];
    if (we) begin
      if (sz) b[lane] = wd[7:0];
      else for (int i = 0; i < 4; i++) b[i] = wd[31 - 8*i -: 8];
      mdl[sel][idx] = {b[0], b[1], b[2], b[3]};
    end
    rd = {b[0], b[1], b[2], b[3]};
  endtask

  task automatic chk_reset(input int sel);
    check("rst_ready", get_ready(sel), 1);
    check("rst_resp_valid", get_rv(sel), 0);
    check("rst_err", get_err(sel), 0);
    check("rst_readdata", get_rd(sel), 0);
  endtask

  task automatic wait_accept(input int sel);
    int n = 0;
    while (!get_ready(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 50), 1);
  endtask

  task automatic do_txn(input int sel, input bit we, input bit sz, input bit [31:0] a,
                        input bit [31:0] wd, output logic [31:0] rd);
    bit [31:0] exp_rd;
    bit        exp_e;
    int        k;
    model_op(sel, we, sz, a, wd, exp_rd, exp_e);
    @(negedge clk);
    drive(sel, 1, we, sz, a, wd);
    wait_accept(sel);
    @(negedge clk);
    drive(sel, 0, 0, 0, 0, 0);
    k = 1;
    while (!get_rv(sel) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, (sel == 0) ? 3 : 1);
    check("readdata", get_rd(sel), exp_rd);
    check("err", get_err(sel), exp_e);
    check("ready_in_resp", get_ready(sel), 0);
    rd = get_rd(sel);
    @(negedge clk);
    check("resp_one_cycle", get_rv(sel), 0);
  endtask

  initial begin
    logic [31:0] rd;
    bit   [31:0] exp_rd;
    bit          exp_e;
    int          k;
    bit   [31:0] ta [3];
    bit   [31:0] td [3];
    bit          twe [3];

    reset_a = 0;
    reset_b = 0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    #12;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    reset_a = 1;
    reset_b = 1;

    // Bring the arrays to a known all-zero state.
    for (int i = 0; i < DEPTH; i++) begin
      do_txn(0, 1, 0, 32'(i * 4), 0, rd);
      do_txn(1, 1, 0, 32'(i * 4), 0, rd);
    end

    // Word write / read, byte lanes, misalignment, wrap
    do_txn(0, 1, 0, 32'h10, 32'hDEADBEEF, rd);
    check("w_word_rd", rd, 32'hDEADBEEF);
    do_txn(0, 0, 0, 32'h10, 0, rd);
    check("r_word", rd, 32'hDEADBEEF);
    do_txn(0, 1, 1, 32'h11, 32'h000000AA, rd);
    do_txn(0, 0, 0, 32'h10, 0, rd);
    check("byte_lane1", rd, 32'hDEAABEEF);
    do_txn(0, 1, 1, 32'h13, 32'h00000055, rd);
    do_txn(0, 0, 0, 32'h10, 0, rd);
    check("byte_lane3", rd, 32'hDEAABE55);
    do_txn(0, 0, 0, 32'h12, 0, rd);
    check("misaligned_rd", rd, 32'h0);
    do_txn(0, 1, 0, 32'h12, 32'hFFFFFFFF, rd);
    do_txn(0, 0, 0, 32'h10, 0, rd);
    check("misaligned_nowrite", rd, 32'hDEAABE55);
    do_txn(0, 0, 1, 32'h13, 0, rd);
    check("byte_read_full", rd, 32'hDEAABE55);
    do_txn(0, 1, 0, 32'h100, 32'h12345678, rd);
    do_txn(0, 0, 0, 32'h000, 0, rd);
    check("addr_wrap", rd, 32'h12345678);

    // Reset in the first WAIT cycle drops the write
    @(negedge clk);
    drive(0, 1, 1, 0, 32'h20, 32'hCAFEF00D);
    wait_accept(0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset_a = 0;
    #1;
    chk_reset(0);
    @(negedge clk);
    reset_a = 1;
    do_txn(0, 0, 0, 32'h20, 0, rd);
    check("dropped_write", rd, 32'h0);

    // Reset during RESP keeps the committed write
    model_op(0, 1, 0, 32'h24, 32'h0BADF00D, exp_rd, exp_e);
    @(negedge clk);
    drive(0, 1, 1, 0, 32'h24, 32'h0BADF00D);
    wait_accept(0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    k = 1;
    while (!get_rv(0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("resp_before_reset", get_rv(0), 1);
    reset_a = 0;
    #1;
    chk_reset(0);
    @(negedge clk);
    reset_a = 1;
    do_txn(0, 0, 0, 32'h24, 0, rd);
    check("committed_write", rd, 32'h0BADF00D);

    // LATENCY=0 with req_valid held high across three back-to-back requests
    ta = '{32'h40, 32'h44, 32'h40};
    td = '{32'h11112222, 32'h33334444, 32'h0};
    twe = '{1, 1, 0};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("b2b_ready", get_ready(1), 1);
      drive(1, 1, twe[i], 0, ta[i], td[i]);
      model_op(1, twe[i], 0, ta[i], td[i], exp_rd, exp_e);
      @(negedge clk);
      check("b2b_resp", get_rv(1), 1);
      check("b2b_ready_resp", get_ready(1), 0);
      check("b2b_data", get_rd(1), exp_rd);
      if (i == 2) drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    check("b2b_no_extra0", get_rv(1), 0);
    @(negedge clk);
    check("b2b_no_extra1", get_rv(1), 0);
    check("b2b_third_read", exp_rd, 32'h11112222);
    do_txn(1, 0, 0, 32'h44, 0, rd);
    check("b2b_second_write", rd, 32'h33334444);

    // Random traffic on both responders
    for (int i = 0; i < 300; i++) begin
      int sel = i % 2;
      do_txn(sel, 1'($urandom), 1'($urandom), 32'($urandom_range(0, 1023)), $urandom, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
